// File: rtl/vram_scan_arbiter.sv
// Arbitrates a synchronous single-port VRAM between display prefetch and a host
// port; prefetched words are unpacked into two RGB332 pixels for the DAC.
module vram_scan_arbiter #(
  parameter int ADDR_W      = 18,
  parameter int FRAME_WORDS = 153600,
  parameter int FIFO_DEPTH  = 4,
  parameter int URGENT_LVL  = 2
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              pix_en,
  input  logic [9:0]        CounterX,
  input  logic [9:0]        CounterY,
  input  logic              inDisplayArea,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [15:0]       host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [15:0]       host_rdata,
  output logic              vram_en,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [15:0]       vram_wdata,
  input  logic [15:0]       vram_rdata,
  output logic [7:0]        pixel,
  output logic              underflow
);

  localparam int DATA_W = 16;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W  = $clog2(FIFO_DEPTH + 3);
  localparam logic [ADDR_W-1:0] FRAME_END = ADDR_W'(FRAME_WORDS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DISP = 2'd1;
  localparam logic [1:0] ST_HOST = 2'd2;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  logic [1:0]        grant_p0;
  logic [1:0]        owner_p1;
  logic              restart_p0;
  logic              need_p0;
  logic              urgent_p0;
  logic [OCC_W-1:0]  occ_p0;
  logic              disp_vld_p1;
  logic              disp_vld_p2;
  logic              host_vld_p2;
  logic [ADDR_W-1:0] fetch_addr;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  fifo_lvl;
  logic              half;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

  // Stage p0: arbitration decision. Display reads are suppressed in the
  // restart cycle because fetch_addr is being rewound there.
  always_comb begin
    restart_p0  = pix_en && (CounterY == 10'd480) && (CounterX == 10'd0);
    disp_vld_p1 = (owner_p1 == ST_DISP);
    occ_p0      = OCC_W'(fifo_lvl) + OCC_W'(disp_vld_p1) + OCC_W'(disp_vld_p2);
    need_p0     = (occ_p0 < OCC_W'(FIFO_DEPTH)) && (fetch_addr < FRAME_END) && !restart_p0;
    urgent_p0   = need_p0 && (occ_p0 < OCC_W'(URGENT_LVL));
    grant_p0    = ST_IDLE;
    if (urgent_p0)     grant_p0 = ST_DISP;
    else if (host_req) grant_p0 = ST_HOST;
    else if (need_p0)  grant_p0 = ST_DISP;
  end

  assign host_gnt    = Reset && (grant_p0 == ST_HOST);
  assign host_rvalid = host_vld_p2;
  assign host_rdata  = host_vld_p2 ? vram_rdata : '0;

  assign head = fifo_mem[rd_ptr];
  assign push = disp_vld_p2 && !restart_p0;
  assign pop  = pix_en && inDisplayArea && (fifo_lvl != '0) && half && !restart_p0;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      owner_p1    <= ST_IDLE;
      vram_en     <= 1'b0;
      vram_we     <= 1'b0;
      vram_addr   <= '0;
      vram_wdata  <= '0;
      disp_vld_p2 <= 1'b0;
      host_vld_p2 <= 1'b0;
      fetch_addr  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_lvl    <= '0;
      half        <= 1'b0;
      pixel       <= '0;
      underflow   <= 1'b0;
    end else begin
      // Stage p1: registered VRAM command.
      owner_p1   <= grant_p0;
      vram_en    <= (grant_p0 != ST_IDLE);
      vram_we    <= (grant_p0 == ST_HOST) && host_we;
      vram_addr  <= (grant_p0 == ST_HOST) ? host_addr :
                    (grant_p0 == ST_DISP) ? fetch_addr : '0;
      vram_wdata <= (grant_p0 == ST_HOST) ? host_wdata : '0;

      // Stage p2: read data returns; a restart makes display reads in flight stale.
      disp_vld_p2 <= disp_vld_p1 && !restart_p0;
      host_vld_p2 <= (owner_p1 == ST_HOST) && !vram_we;

      if (restart_p0)                fetch_addr <= '0;
      else if (grant_p0 == ST_DISP)  fetch_addr <= fetch_addr + ADDR_W'(1);

      if (restart_p0) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_lvl <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        if (push && !pop)      fifo_lvl <= fifo_lvl + LVL_W'(1);
        else if (pop && !push) fifo_lvl <= fifo_lvl - LVL_W'(1);
      end

      if (pix_en) begin
        if (restart_p0) begin
          pixel     <= '0;
          half      <= 1'b0;
          underflow <= 1'b0;
        end else if (inDisplayArea && (fifo_lvl != '0)) begin
          pixel <= half ? head[15:8] : head[7:0];
          half  <= ~half;
        end else if (inDisplayArea) begin
          pixel     <= '0;
          underflow <= 1'b1;
        end else begin
          pixel <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= vram_rdata;
  end

endmodule

// File: doc/vram_scan_arbiter.md
Name: vram_scan_arbiter

Overview:
- Shares one single-port video RAM between two requesters:
  - the display scan-out path, fed by the sync generator's CounterX/CounterY/inDisplayArea;
  - a host port for pixel reads and writes.
- Prefetches framebuffer words into a small FIFO so the display never stalls.
- Unpacks each 16-bit word into two 8-bit RGB332 pixels, one per pixel-clock enable.
- Sits between the sync generator, the VRAM macro and the colour DAC output stage.

Parameters:
- ADDR_W, 18, VRAM word-address width.
- FRAME_WORDS, 153600, words per frame (640x480 pixels / 2 pixels per word).
- FIFO_DEPTH, 4, prefetch FIFO entries (16-bit words).
- URGENT_LVL, 2, display becomes top priority when (FIFO level + in-flight reads) < URGENT_LVL.

Ports:
- clk  input  1  system clock (50 MHz).
- Reset  input  1  asynchronous, active-low reset; block is in reset while Reset==0.
- pix_en  input  1  pixel-clock enable, one clk pulse per pixel (every 2nd clk).
- CounterX  input  10  horizontal counter from the sync generator.
- CounterY  input  10  vertical counter from the sync generator.
- inDisplayArea  input  1  visible-area flag from the sync generator.
- host_req  input  1  host access request.
- host_we  input  1  1=write, 0=read.
- host_addr  input  ADDR_W  host word address.
- host_wdata  input  16  host write data.
- host_gnt  output  1  one-cycle grant pulse.
- host_rvalid  output  1  host read data valid.
- host_rdata  output  16  host read data.
- vram_en  output  1  VRAM access enable.
- vram_we  output  1  VRAM write enable.
- vram_addr  output  ADDR_W  VRAM address.
- vram_wdata  output  16  VRAM write data.
- vram_rdata  input  16  VRAM read data; valid the cycle after vram_en (synchronous RAM).
- pixel  output  8  RGB332 pixel to the DAC.
- underflow  output  1  sticky flag: FIFO was empty when a visible pixel was needed.

Behaviour:
- Reset (async, Reset==0):
  - all outputs go to 0;
  - FIFO is emptied; fetch_addr=0; half=0; in-flight tags are cleared; owner state=IDLE.
- Reset mid-operation aborts any access that has not completed; a held host_req is granted normally after release.
- Owner FSM states: IDLE, DISP, HOST. The state records the owner of the VRAM slot issued this cycle.
- One arbitration decision per clk. Definitions:
  - occ = FIFO level + in-flight display reads;
  - need = occ < FIFO_DEPTH and fetch_addr < FRAME_WORDS;
  - urgent = need and occ < URGENT_LVL.
- Grant priority in each cycle:
  1. urgent display -> DISP;
  2. otherwise host_req -> HOST;
  3. otherwise need -> DISP;
  4. otherwise IDLE.
- Issue timing:
  - the decision is made in cycle T; vram_en, vram_we, vram_addr and vram_wdata are registered and driven in cycle T+1;
  - host_gnt pulses in cycle T;
  - a display grant post-increments fetch_addr.
- Read return:
  - vram_rdata is captured at T+2;
  - a display read is pushed into the FIFO at T+2;
  - a host read drives host_rvalid=1 and host_rdata=vram_rdata for exactly one cycle at T+2.
- Host handshake:
  - host holds req, we, addr and wdata stable until it sees host_gnt;
  - a back-to-back req after gnt is legal;
  - a host write is complete at issue (T+1); no rvalid is produced for writes.
- Host bandwidth guarantee: at one pix_en per 2 clk, display needs 1 word per 4 clk, so the host receives at least 3 of every 4 slots in steady state.
- host_addr >= FRAME_WORDS is passed through unchecked.
- Pixel unpack, on pix_en:
  - if inDisplayArea=1 and FIFO is non-empty: pixel = half ? word[15:8] : word[7:0]; half toggles; the word is popped when half was 1;
  - if inDisplayArea=1 and FIFO is empty: pixel=0x00, underflow<=1;
  - if inDisplayArea=0: pixel=0x00.
- Frame restart: when pix_en && CounterY==480 && CounterX==0:
  - fetch_addr<=0, FIFO flushed, half<=0, underflow<=0;
  - in-flight display reads are tagged stale and dropped on return.
- Prefetch continues during blanking, so the FIFO is full before pixel (0,0).
- Frame end: fetch_addr saturates at FRAME_WORDS and no further display reads are issued until frame restart.
- Simultaneous FIFO push and pop in the same cycle is legal; the level is unchanged.
- An in-flight stale read never pushes into the FIFO.

Test Plan:
- Reset then idle host, frame restart pulse -> 4 display reads at addresses 0,1,2,3 on consecutive cycles; FIFO full; no host_gnt; pixel=0x00 during blank.
- VRAM word 0=0xB2A1, word 1=0xD4C3; enter display area -> pixel sequence 0xA1, 0xB2, 0xC3, 0xD4 on successive pix_en; underflow=0.
- Host write addr=0x00010, data=0x1234 while FIFO is full -> host_gnt at T; at T+1 vram_en=1, vram_we=1, vram_addr=0x00010, vram_wdata=0x1234.
- Host holds read req continuously during active video -> display never underflows; host_rvalid at least 3 times per 4 clk in steady state; each host_rdata equals the word stored at the requested address.
- Force VRAM stall by holding host priority (occ kept at 1 while urgent is blocked) -> pixel=0x00 and underflow=1; underflow clears at the next frame-restart pulse.
- Assert Reset=0 between a DISP grant and its data return -> all outputs 0 immediately; after release no stale push occurs and fetch resumes at address 0.
